sr165_chain_reader: RTL and testbench
=====================================

Name: sr165_chain_reader

Overview:
- Parametrised FPGA-side master for a cascade of CHIPS 74HC165 parallel-in/serial-out shift registers, e.g. limit switches, encoder and alarm inputs.
- Generates load_n and sclk and captures sdi MSB-first, then presents the full parallel word with a valid pulse and a change flag.
- Supports single-shot scans and continuous back-to-back scanning.
- Sits between the external input-expander chain and the control register file.

Parameters:
CHIPS, 4, number of cascaded 8-bit chips; WIDTH = 8*CHIPS (derived, not overridable)
CLK_DIV, 4, duration in clk cycles of each sclk phase (low and high); must be >= 3
LOAD_CYCLES, 2, clk cycles load_n is held low; must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle scan request; sampled only in IDLE
auto_en  input  1  level; while high, a new scan starts immediately after each completion
sdi  input  1  serial data from the last chip in the chain; asynchronous to clk
load_n  output  1  parallel-load strobe to the chain, active-low
sclk  output  1  shift clock to the chain; idles low
busy  output  1  high from the first LOAD cycle through the DONE cycle
data_out  output  WIDTH  last completed word; bit WIDTH-1 is the first bit received
valid  output  1  one-cycle pulse when data_out updates
changed  output  1  one-cycle pulse coincident with valid when the new word differs from the previous data_out

Behaviour:
- Reset (async, immediate, also mid-scan):
  - load_n=1, sclk=0, busy=0, valid=0, changed=0, data_out=0.
  - Shift register, counters and synchroniser cleared; state=IDLE.
- sdi passes through a 2-flop synchroniser (sdi_s). CLK_DIV >= 3 guarantees sdi_s is stable at each sample point.
- FSM states: IDLE -> LOAD -> SETTLE -> LOW -> HIGH -> LOW ... -> DONE.
  - IDLE: (start | auto_en) -> LOAD next cycle.
  - LOAD: load_n=0 for LOAD_CYCLES cycles, sclk=0.
  - SETTLE: load_n=1, sclk=0 for CLK_DIV cycles.
  - LOW: sclk=0 for CLK_DIV cycles. On the last LOW cycle, sdi_s is shifted in: shreg <= {shreg[WIDTH-2:0], sdi_s}. Bit counter increments. If WIDTH bits have been taken -> DONE, else -> HIGH.
  - HIGH: sclk=1 for CLK_DIV cycles, then -> LOW. The rising edge of sclk advances the chain.
  - DONE: one cycle. data_out<=shreg, valid=1, changed=(shreg != data_out). Then -> LOAD if auto_en, else IDLE.
- Per scan: exactly one load_n low pulse and exactly WIDTH-1 sclk rising edges. No extra edge after the last bit.
- Latency: start sampled in IDLE at cycle T -> valid at cycle T + LOAD_CYCLES + 2*WIDTH*CLK_DIV + 1.
- busy=1 in every state except IDLE.
- start outside IDLE is ignored, with no queuing. start and auto_en high together start a single scan.
- auto_en dropping mid-scan: the current scan completes normally, then the FSM returns to IDLE.
- First scan after reset compares against 0: changed=1 iff word != 0.
- data_out holds its value between scans. It is never partially updated.

Test Plan:
Default bench setup: CHIPS=4, CLK_DIV=4, LOAD_CYCLES=2; sdi driven by the team's 74HC165 behavioural chain model.
1. Chain inputs 0xA5C30F81, one start pulse -> valid exactly 259 cycles after start, data_out=0xA5C30F81, changed=1, 31 sclk rising edges, one 2-cycle load_n pulse, busy low after DONE.
2. Second start with unchanged inputs -> data_out=0xA5C30F81, valid=1, changed=0.
3. auto_en=1, inputs toggled between 0x00000001 and 0x80000000 every other scan -> back-to-back scans with 1 idle-free cycle between DONE and LOAD; changed=1 only on scans where the word differs.
4. start pulses during SETTLE, LOW and HIGH -> ignored: no restart, scan length unchanged, a single valid.
5. rst asserted after the 10th sclk edge -> same cycle: load_n=1, sclk=0, busy=0, data_out=0. A subsequent start with inputs 0xFFFFFFFF -> data_out=0xFFFFFFFF, changed=1.
6. CHIPS=1, CLK_DIV=3, LOAD_CYCLES=1, inputs 0x80 then 0x01 -> data_out=0x80 then 0x01, 7 sclk edges per scan, valid 50 cycles after start.

Source files
------------

// File: rtl/sr165_chain_reader.sv
// sr165_chain_reader
// Master for a cascade of 74HC165 parallel-in/serial-out shift registers.
// Each scan does the following:
//   - pulses load_n low to capture the chip inputs;
//   - clocks the chain with sclk;
//   - shifts sdi in MSB-first;
//   - publishes the whole word on data_out, with a valid pulse and a change flag.
// Scans are started by a single start pulse, or run back-to-back while auto_en is high.
// CLK_DIV must be >= 3 so the synchronised serial input is settled at every sample point.
// LOAD_CYCLES must be >= 1.
module sr165_chain_reader #(
    parameter int  CHIPS       = 4,
    parameter int  CLK_DIV     = 4,
    parameter int  LOAD_CYCLES = 2,
    localparam int WIDTH       = 8 * CHIPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             auto_en,
    input  logic             sdi,
    output logic             load_n,
    output logic             sclk,
    output logic             busy,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             changed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    // The phase counter covers both the load pulse and each sclk half period.
    localparam int PH_MAX = (CLK_DIV > LOAD_CYCLES) ? CLK_DIV : LOAD_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [PH_W-1:0]  LOAD_LAST = PH_W'(LOAD_CYCLES - 1);
    localparam logic [PH_W-1:0]  DIV_LAST  = PH_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               changed_q, changed_d;
    logic               load_n_q, load_n_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;
    logic               sdi_meta_q, sdi_s_q;
    logic [WIDTH-1:0]   shift_word;

    // Two-flop synchroniser for the serial input, which is asynchronous to clk.
    // NOTE: every flop is written with <=. All flops then update together at the
    //       edge, and no block sees another block's new value within the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdi_meta_q <= 1'b0;
            sdi_s_q    <= 1'b0;
        end else begin
            sdi_meta_q <= sdi;
            sdi_s_q    <= sdi_meta_q;
        end
    end

    // Scan sequencer: next state, phase/bit counting, shifting and word publication.
    // NOTE: every signal gets a default before the case. A path that leaves a signal
    //       unassigned would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        changed_d  = 1'b0;
        shift_word = {shreg_q[WIDTH-2:0], sdi_s_q};

        case (state_q)
            S_IDLE: begin
                // start and auto_en are only honoured here. There is no queuing.
                if (start || auto_en) begin
                    state_d = S_LOAD;
                    ph_d    = '0;
                    bit_d   = '0;
                end
            end

            S_LOAD: begin
                if (ph_q == LOAD_LAST) begin
                    state_d = S_SETTLE;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_SETTLE: begin
                // Gives the first bit (already on sdi after the load) time to
                // pass through the synchroniser.
                if (ph_q == DIV_LAST) begin
                    state_d = S_LOW;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_LOW: begin
                if (ph_q == DIV_LAST) begin
                    ph_d    = '0;
                    shreg_d = shift_word;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        // Last bit: skip the final HIGH so no extra sclk edge is
                        // produced. The whole word is published at once.
                        state_d   = S_DONE;
                        data_d    = shift_word;
                        valid_d   = 1'b1;
                        changed_d = (shift_word != data_q);
                    end else begin
                        state_d = S_HIGH;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_HIGH: begin
                if (ph_q == DIV_LAST) begin
                    state_d = S_LOW;
                    ph_d    = '0;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end

            S_DONE: begin
                ph_d    = '0;
                bit_d   = '0;
                state_d = auto_en ? S_LOAD : S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Chain-facing strobes are decoded from the next state and then registered,
    // so the pins are glitch-free and line up with the state they belong to.
    always_comb begin
        load_n_d = (state_d != S_LOAD);
        sclk_d   = (state_d == S_HIGH);
        busy_d   = (state_d != S_IDLE);
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            ph_q      <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            load_n_q  <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            load_n_q  <= load_n_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
        end
    end

    assign load_n   = load_n_q;
    assign sclk     = sclk_q;
    assign busy     = busy_q;
    assign data_out = data_q;
    assign valid    = valid_q;
    assign changed  = changed_q;

endmodule

// File: tb/tb_sr165_chain_reader.sv
// tb_sr165_chain_reader
// Drives two readers from behavioural 74HC165 chain models:
//   - a 4-chip reader (CLK_DIV=4, LOAD_CYCLES=2);
//   - a 1-chip reader (CLK_DIV=3, LOAD_CYCLES=1).
// Expected words, flags, latencies and edge counts are hand-computed constants.
module tb_sr165_chain_reader;

    typedef struct {
        bit          sel;         // 0: 4-chip reader, 1: 1-chip reader
        logic [31:0] par;         // chain parallel inputs
        logic [31:0] exp_data;
        bit          exp_changed;
        bit          inject;      // extra start pulses during SETTLE/LOW/HIGH
    } scan_vec_t;

    typedef struct {
        logic [31:0] par;
        bit          exp_changed;
    } auto_vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0, auto_en = 1'b0;
    logic        sdi_a, sdi_b;
    logic        load_n_a, sclk_a, busy_a, valid_a, changed_a;
    logic        load_n_b, sclk_b, busy_b, valid_b, changed_b;
    logic [31:0] data_out_a;
    logic [7:0]  data_out_b;

    logic [31:0] par_a = '0, chain_a = '0;
    logic [7:0]  par_b = '0, chain_b = '0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int edges_a = 0, edges_b = 0, loads_a = 0, loads_b = 0;
    int lowcyc_a = 0, lowcyc_b = 0, valids_a = 0, valids_b = 0;
    bit use_b = 1'b0;

    always #5 clk = ~clk;

    sr165_chain_reader #(.CHIPS(4), .CLK_DIV(4), .LOAD_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .auto_en(auto_en), .sdi(sdi_a),
        .load_n(load_n_a), .sclk(sclk_a), .busy(busy_a), .data_out(data_out_a),
        .valid(valid_a), .changed(changed_a)
    );

    sr165_chain_reader #(.CHIPS(1), .CLK_DIV(3), .LOAD_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .auto_en(1'b0), .sdi(sdi_b),
        .load_n(load_n_b), .sclk(sclk_b), .busy(busy_b), .data_out(data_out_b),
        .valid(valid_b), .changed(changed_b)
    );

    // 74HC165 chain models: parallel load on load_n low, shift toward Q7 on sclk rise.
    always @(posedge sclk_a or negedge load_n_a)
        if (!load_n_a) chain_a <= par_a; else chain_a <= {chain_a[30:0], 1'b0};
    always @(posedge sclk_b or negedge load_n_b)
        if (!load_n_b) chain_b <= par_b; else chain_b <= {chain_b[6:0], 1'b0};
    assign sdi_a = chain_a[31];
    assign sdi_b = chain_b[7];

    // Free-running event counters; tests look at differences between snapshots.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!load_n_a) lowcyc_a = lowcyc_a + 1;
        if (!load_n_b) lowcyc_b = lowcyc_b + 1;
        if (valid_a)   valids_a = valids_a + 1;
        if (valid_b)   valids_b = valids_b + 1;
    end
    always @(posedge sclk_a)   edges_a = edges_a + 1;
    always @(posedge sclk_b)   edges_b = edges_b + 1;
    always @(negedge load_n_a) loads_a = loads_a + 1;
    always @(negedge load_n_b) loads_b = loads_b + 1;

    logic        cur_valid, cur_changed, cur_busy, cur_load_n, cur_sclk;
    logic [31:0] cur_data;
    assign cur_valid   = use_b ? valid_b   : valid_a;
    assign cur_changed = use_b ? changed_b : changed_a;
    assign cur_busy    = use_b ? busy_b    : busy_a;
    assign cur_load_n  = use_b ? load_n_b  : load_n_a;
    assign cur_sclk    = use_b ? sclk_b    : sclk_a;
    assign cur_data    = use_b ? {24'd0, data_out_b} : data_out_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input bit v);
        start_a = v && !use_b;
        start_b = v && use_b;
    endtask

    // Steps negedges until valid is seen or the budget runs out. Optionally
    // fires stray start pulses at cycle offsets 4 (SETTLE), 8 (LOW) and 12 (HIGH).
    task automatic wait_valid(input int t0, input bit inject, input int budget, output bit ok);
        int k;
        int off;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < budget) begin
            @(negedge clk);
            off = cyc - t0;
            set_start(inject && (off == 4 || off == 8 || off == 12));
            if (cur_valid) ok = 1'b1;
            k = k + 1;
        end
        set_start(1'b0);
    endtask

    task automatic run_scan(input scan_vec_t v);
        int t0, e0, l0, c0, n0, exp_lat, exp_edges, exp_low;
        bit ok;
        use_b     = v.sel;
        exp_lat   = v.sel ? 50 : 259;
        exp_edges = v.sel ? 7  : 31;
        exp_low   = v.sel ? 1  : 2;
        if (v.sel) par_b = v.par[7:0]; else par_a = v.par;
        e0 = v.sel ? edges_b  : edges_a;
        l0 = v.sel ? loads_b  : loads_a;
        c0 = v.sel ? lowcyc_b : lowcyc_a;
        n0 = v.sel ? valids_b : valids_a;
        t0 = cyc;
        set_start(1'b1);
        wait_valid(t0, v.inject, 400, ok);
        check("valid_seen", 32'(ok), 32'd1);
        check("latency", 32'(cyc - t0), 32'(exp_lat));
        check("data_out", cur_data, v.exp_data);
        check("changed", 32'(cur_changed), 32'(v.exp_changed));
        check("busy_in_done", 32'(cur_busy), 32'd1);
        @(negedge clk);
        check("idle_after_done", {29'd0, cur_busy, cur_load_n, cur_sclk}, 32'b010);
        check("valid_one_cycle", 32'(cur_valid), 32'd0);
        repeat (20) @(negedge clk);
        check("sclk_edges", 32'((v.sel ? edges_b : edges_a) - e0), 32'(exp_edges));
        check("load_pulses", 32'((v.sel ? loads_b : loads_a) - l0), 32'd1);
        check("load_low_cycles", 32'((v.sel ? lowcyc_b : lowcyc_a) - c0), 32'(exp_low));
        check("valid_count", 32'((v.sel ? valids_b : valids_a) - n0), 32'd1);
        check("stays_idle", 32'(cur_busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        scan_vec_t scans[6];
        auto_vec_t autos[5];
        scan_vec_t v;
        int t0, e0, l0, n0, k;
        bit ok;

        scans[0] = '{sel: 1'b0, par: 32'hA5C30F81, exp_data: 32'hA5C30F81, exp_changed: 1'b1, inject: 1'b0};
        scans[1] = '{sel: 1'b0, par: 32'hA5C30F81, exp_data: 32'hA5C30F81, exp_changed: 1'b0, inject: 1'b0};
        scans[2] = '{sel: 1'b0, par: 32'h3C3C3C3C, exp_data: 32'h3C3C3C3C, exp_changed: 1'b1, inject: 1'b1};
        scans[3] = '{sel: 1'b1, par: 32'h00000080, exp_data: 32'h00000080, exp_changed: 1'b1, inject: 1'b0};
        scans[4] = '{sel: 1'b1, par: 32'h00000001, exp_data: 32'h00000001, exp_changed: 1'b1, inject: 1'b0};
        scans[5] = '{sel: 1'b1, par: 32'h00000001, exp_data: 32'h00000001, exp_changed: 1'b0, inject: 1'b1};

        autos[0] = '{par: 32'h00000001, exp_changed: 1'b1};
        autos[1] = '{par: 32'h00000001, exp_changed: 1'b0};
        autos[2] = '{par: 32'h80000000, exp_changed: 1'b1};
        autos[3] = '{par: 32'h80000000, exp_changed: 1'b0};
        autos[4] = '{par: 32'h00000001, exp_changed: 1'b1};

        // Reset state, while held and after release.
        repeat (3) @(negedge clk);
        check("rst_a_pins", {29'd0, load_n_a, sclk_a, busy_a}, 32'b100);
        check("rst_a_flags", {30'd0, valid_a, changed_a}, 32'd0);
        check("rst_a_data", data_out_a, 32'd0);
        check("rst_b_pins", {29'd0, load_n_b, sclk_b, busy_b}, 32'b100);
        check("rst_b_data", {24'd0, data_out_b}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_a_pins", {29'd0, load_n_a, sclk_a, busy_a}, 32'b100);
        check("post_rst_b_pins", {29'd0, load_n_b, sclk_b, busy_b}, 32'b100);

        // Single-shot scans on both readers.
        for (int i = 0; i < 6; i++) run_scan(scans[i]);

        // Continuous scanning; auto_en dropped in the middle of the last scan.
        use_b = 1'b0;
        par_a = autos[0].par;
        e0 = edges_a;
        l0 = loads_a;
        n0 = valids_a;
        t0 = cyc;
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(t0, 1'b0, 400, ok);
            check("auto_valid_seen", 32'(ok), 32'd1);
            check("auto_interval", 32'(cyc - t0), 32'd259);
            check("auto_data", data_out_a, autos[i].par);
            check("auto_changed", 32'(changed_a), 32'(autos[i].exp_changed));
            t0 = cyc;
            if (i < 4) begin
                par_a = autos[i+1].par;
                @(negedge clk);
                check("auto_back_to_back", {30'd0, busy_a, load_n_a}, 32'b10);
                if (i == 3) begin
                    repeat (40) @(negedge clk);
                    auto_en = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("auto_stop_idle", 32'(busy_a), 32'd0);
        repeat (30) @(negedge clk);
        check("auto_valid_count", 32'(valids_a - n0), 32'd5);
        check("auto_sclk_edges", 32'(edges_a - e0), 32'd155);
        check("auto_load_pulses", 32'(loads_a - l0), 32'd5);

        // Reset in the middle of a scan, after the 10th sclk rising edge.
        par_a = 32'h12345678;
        e0 = edges_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        k = 0;
        while ((edges_a - e0) < 10 && k < 300) begin
            @(negedge clk);
            k = k + 1;
        end
        check("reach_10_edges", 32'((edges_a - e0) >= 10), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midscan_rst_pins", {29'd0, load_n_a, sclk_a, busy_a}, 32'b100);
        check("midscan_rst_data", data_out_a, 32'd0);
        check("midscan_rst_valid", 32'(valid_a), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("no_restart_after_rst", 32'(busy_a), 32'd0);

        v = '{sel: 1'b0, par: 32'hFFFFFFFF, exp_data: 32'hFFFFFFFF, exp_changed: 1'b1, inject: 1'b0};
        run_scan(v);
        v = '{sel: 1'b1, par: 32'h00000080, exp_data: 32'h00000080, exp_changed: 1'b1, inject: 1'b0};
        run_scan(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
